// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with programmable wait states
// Optional misaligned-access error reporting is enabled by defining MISALIGN_CHECK_EN.

module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              wait_cnt;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_be;
  logic                    access_edge;
  logic                    access_ok;
  logic [31:0]             mem [DEPTH];

  // Upper address bits wrap the array; the byte offset only matters for the misalign check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign busy        = (state != S_IDLE);
  assign access_edge = (state == S_WAIT) && (wait_cnt == 4'd0);

`ifdef MISALIGN_CHECK_EN
  logic [1:0] lat_off;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      lat_off <= req_addr[1:0];
    end
  end

  assign access_ok = (lat_off == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (access_edge) begin
      resp_err <= !access_ok;
    end else if (state == S_RESP && resp_ready) begin
      resp_err <= 1'b0;
    end
  end
`else
  assign access_ok = 1'b1;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req_valid)   next_state = S_WAIT;
      S_WAIT: if (access_edge) next_state = S_RESP;
      S_RESP: if (resp_ready)  next_state = S_IDLE;
      default:                 next_state = S_IDLE;
    endcase
  end

  // Request fields are only captured in IDLE, so a request presented while busy is dropped.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      lat_write <= req_write;
      lat_idx   <= req_addr[ADDR_WIDTH+1:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wait_cnt <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!lat_write && access_ok) begin
            resp_rdata <= mem[lat_idx];
          end else begin
            resp_rdata <= 32'd0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
          end
        end
        default: begin
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Array has no reset; a reset landing on the access edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && access_edge && lat_write && access_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// Drives a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance with the same request stream.

module tb_data_mem_responder;

`ifdef MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        req_ready,  resp_valid,  resp_err,  busy;
  logic [31:0] resp_rdata;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [31:0] resp_rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " req_ready"},   32'(req_ready),   32'd1);
    check({tag, " resp_valid"},  32'(resp_valid),  32'd0);
    check({tag, " resp_rdata"},  resp_rdata,       32'd0);
    check({tag, " resp_err"},    32'(resp_err),    32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " busy0"},       32'(busy0),       32'd0);
    check({tag, " resp_valid0"}, 32'(resp_valid0), 32'd0);
  endtask

  // Issues one request and waits for both instances to respond, bounded at 20 cycles.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit release_resp,
                        output logic [31:0] rd, output logic [31:0] rd0,
                        output logic er, output logic er0,
                        output int lat, output int lat0, output logic rdy_hi);
    rd = 32'hx; rd0 = 32'hx; er = 1'bx; er0 = 1'bx;
    lat = -1; lat0 = -1; rdy_hi = 1'b0;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (req_ready || req_ready0) rdy_hi = 1'b1;
      if (resp_valid0 && lat0 < 0) begin
        lat0 = i; rd0 = resp_rdata0; er0 = resp_err0;
      end
      if (resp_valid && lat < 0) begin
        lat = i; rd = resp_rdata; er = resp_err;
      end
      if (lat >= 0 && lat0 >= 0) break;
    end
    if (release_resp) begin
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
  endtask

  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd, rd0;
    logic        er, er0, rdy_hi;
    int          lat, lat0;
    do_req(wr, addr, wdata, be, 1'b1, rd, rd0, er, er0, lat, lat0, rdy_hi);
    check({tag, " rdata"},      rd,             exp_rd);
    check({tag, " rdata0"},     rd0,            exp_rd);
    check({tag, " err"},        32'(er),        32'(exp_err));
    check({tag, " latency"},    32'(lat),       32'd3);
    check({tag, " latency0"},   32'(lat0),      32'd1);
    check({tag, " ready_low"},  32'(rdy_hi),    32'd0);
    check({tag, " idle_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, rd0, held;
    logic        er, er0, rdy_hi, stable;
    int          lat, lat0;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_idle("reset");

    xact("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    xact("st_20",    1'b1, 32'h20, 32'h11223344, 4'hF,    32'h0, 1'b0);
    xact("st_20_be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xact("ld_20",    1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    xact("st_20_be0", 1'b1, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    xact("ld_20_be0", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Back-pressure with a competing store that must be ignored.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, rd0, er, er0, lat, lat0, rdy_hi);
    check("bp first rdata", rd, 32'hDEADBEEF);
    held = resp_rdata;
    stable = 1'b1;
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!resp_valid || resp_rdata !== held || req_ready || !resp_valid0 || req_ready0)
        stable = 1'b0;
    end
    req_valid = 1'b0;
    check("bp stable", 32'(stable), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp release resp_valid", 32'(resp_valid), 32'd0);
    check("bp release req_ready",  32'(req_ready),  32'd1);
    xact("bp ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset in the first WAIT cycle kills the pending store.
    xact("st_30", 1'b1, 32'h30, 32'h1, 4'hF, 32'h0, 1'b0);
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    xact("ld_30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h1, 1'b0);

    xact("st_1004", 1'b1, 32'h1004, 32'hCAFE0001, 4'hF, 32'h0, 1'b0);
    xact("ld_0004", 1'b0, 32'h0004, 32'h0, 4'h0, 32'hCAFE0001, 1'b0);

    xact("ld_12", 1'b0, 32'h12, 32'h0, 4'h0, MIS ? 32'h0 : 32'hDEADBEEF, MIS);

    // Reset while a response is pending discards it.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, rd0, er, er0, lat, lat0, rdy_hi);
    check("rr resp_valid before", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("resp_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
